// File: rtl/buzzer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : buzzer_sched
//  Description : Shares one buzzer between three fixed-pattern requesters
//                (ch0 key click, ch1 timer expiry, ch2 alarm) by strict
//                priority and sequences on/off/count on a tick time base.
//                Optional build macro BUZZER_SCHED_PREEMPT_EN lets a pending
//                higher channel abort the pattern currently playing.
//  Revision    : 1.0 - initial release
// ============================================================================
module buzzer_sched #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int ON0_MS  = 50,
  parameter int OFF0_MS = 0,
  parameter int CNT0    = 1,
  parameter int ON1_MS  = 100,
  parameter int OFF1_MS = 100,
  parameter int CNT1    = 3,
  parameter int ON2_MS  = 250,
  parameter int OFF2_MS = 250,
  parameter int CNT2    = 0
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] cancel,
  output logic       buzz_en,
  output logic       busy,
  output logic [1:0] active_ch,
  output logic [2:0] done
);

  localparam int          c_TICK_DIV = CLK_HZ / TICK_HZ;
  localparam logic [31:0] c_DIV_M1   = 32'(c_TICK_DIV - 1);
  // Terminal values of the tick counter; an OFF time of 0 is never compared
  // because the OFF phase is skipped entirely for that channel.
  localparam logic [15:0] c_ON0_M1   = 16'(ON0_MS - 1);
  localparam logic [15:0] c_ON1_M1   = 16'(ON1_MS - 1);
  localparam logic [15:0] c_ON2_M1   = 16'(ON2_MS - 1);
  localparam logic [15:0] c_OFF0_M1  = 16'(OFF0_MS - 1);
  localparam logic [15:0] c_OFF1_M1  = 16'(OFF1_MS - 1);
  localparam logic [15:0] c_OFF2_M1  = 16'(OFF2_MS - 1);
  localparam logic [7:0]  c_CNT0     = 8'(CNT0);
  localparam logic [7:0]  c_CNT1     = 8'(CNT1);
  localparam logic [7:0]  c_CNT2     = 8'(CNT2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pre;
  logic [15:0] r_ms;
  logic [15:0] w_ms_next;
  logic [7:0]  r_beep;
  logic [7:0]  w_beep_next;
  logic [2:0]  r_pend;
  logic [2:0]  w_pend_eff;
  logic [2:0]  w_clr;
  logic [1:0]  r_active;
  logic [1:0]  w_sel;
  logic        w_start;
  logic        w_fin;
  logic        w_tick;
  logic        w_abort;
  logic        w_preempt;
  logic [15:0] w_on_m1;
  logic [15:0] w_off_m1;
  logic        w_off_zero;
  logic [7:0]  w_cnt;
  logic        r_buzz;
  logic [2:0]  r_done;

  // A cancel arriving in the same cycle as selection suppresses that channel.
  assign w_pend_eff = r_pend & ~cancel;
  assign w_sel      = w_pend_eff[2] ? 2'd2 : (w_pend_eff[1] ? 2'd1 : 2'd0);
  assign w_clr      = w_start ? (3'b001 << w_sel) : 3'b000;
  assign w_tick     = (r_pre == c_DIV_M1);
  assign w_abort    = cancel[r_active] | w_preempt;

  // Pattern constants of the channel currently being played.
  always_comb begin
    w_on_m1    = c_ON0_M1;
    w_off_m1   = c_OFF0_M1;
    w_off_zero = (OFF0_MS == 0);
    w_cnt      = c_CNT0;
    case (r_active)
      2'd1: begin
        w_on_m1    = c_ON1_M1;
        w_off_m1   = c_OFF1_M1;
        w_off_zero = (OFF1_MS == 0);
        w_cnt      = c_CNT1;
      end
      2'd2: begin
        w_on_m1    = c_ON2_M1;
        w_off_m1   = c_OFF2_M1;
        w_off_zero = (OFF2_MS == 0);
        w_cnt      = c_CNT2;
      end
      default: ;
    endcase
  end

`ifdef BUZZER_SCHED_PREEMPT_EN
  // Any pending channel above the active one aborts the current pattern.
  always_comb begin
    case (r_active)
      2'd0:    w_preempt = |r_pend[2:1];
      2'd1:    w_preempt = r_pend[2];
      default: w_preempt = 1'b0;
    endcase
  end
`else
  assign w_preempt = 1'b0;
`endif

  // Next-state, tick-count and beep-count logic of the pattern sequencer.
  always_comb begin
    w_next      = r_state;
    w_ms_next   = r_ms;
    w_beep_next = r_beep;
    w_start     = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_pend_eff) begin
          w_next      = S_ON;
          w_start     = 1'b1;
          w_ms_next   = 16'd0;
          w_beep_next = 8'd0;
        end
      end
      S_ON: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (w_tick) begin
          if (r_ms == w_on_m1) begin
            w_ms_next   = 16'd0;
            w_beep_next = r_beep + 8'd1;
            if ((w_cnt != 8'd0) && ((r_beep + 8'd1) == w_cnt)) begin
              w_next = S_IDLE;
              w_fin  = 1'b1;
            end else if (!w_off_zero) begin
              w_next = S_OFF;
            end
          end else begin
            w_ms_next = r_ms + 16'd1;
          end
        end
      end
      S_OFF: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (w_tick) begin
          if (r_ms == w_off_m1) begin
            w_next    = S_ON;
            w_ms_next = 16'd0;
          end else begin
            w_ms_next = r_ms + 16'd1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, counters, request latches and registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pre    <= 32'd0;
      r_ms     <= 16'd0;
      r_beep   <= 8'd0;
      r_pend   <= 3'b000;
      r_active <= 2'd0;
      r_buzz   <= 1'b0;
      r_done   <= 3'b000;
    end else begin
      r_state <= w_next;
      r_ms    <= w_ms_next;
      r_beep  <= w_beep_next;
      r_pend  <= ((r_pend & ~w_clr) | req) & ~cancel;
      if (w_start) begin
        r_active <= w_sel;
      end
      r_buzz <= (w_next == S_ON);
      r_done <= w_fin ? (3'b001 << r_active) : 3'b000;
      // Held at zero in IDLE so every phase starts on a fresh tick boundary.
      if ((r_state == S_IDLE) || w_tick) begin
        r_pre <= 32'd0;
      end else begin
        r_pre <= r_pre + 32'd1;
      end
    end
  end

  assign buzz_en   = r_buzz;
  assign busy      = (r_state != S_IDLE);
  assign active_ch = busy ? r_active : 2'd0;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buzzer_sched
//  Description : Self-checking bench for buzzer_sched. Directed scenarios are
//                measured as pulse/gap lengths; a random phase is compared
//                cycle by cycle with a phase/remaining-time reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buzzer_sched;

  localparam int D = 10;  // clk1 cycles per tick with the bench settings
  localparam int ON_C  [3] = '{50, 100, 250};
  localparam int OFF_C [3] = '{0, 100, 250};
  localparam int CNT_C [3] = '{1, 3, 0};

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] cancel = 3'b000;
  logic       buzz_en;
  logic       busy;
  logic [1:0] active_ch;
  logic [2:0] done;

  int checks = 0;
  int errors = 0;

  buzzer_sched #(.CLK_HZ(10000), .TICK_HZ(1000)) dut (
    .clk1(clk1), .rst_n(rst_n), .req(req), .cancel(cancel),
    .buzz_en(buzz_en), .busy(busy), .active_ch(active_ch), .done(done)
  );

  always #5 clk1 = ~clk1;

  // Reference model: current phase and cycles remaining in it.
  bit         m_busy, m_on;
  int         m_ch, m_left, m_beeps;
  logic [2:0] m_pend, m_done;

  task automatic model_reset();
    m_busy = 0; m_on = 0; m_ch = 0; m_left = 0; m_beeps = 0;
    m_pend = 3'b000; m_done = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] c);
    logic [2:0] clr, eff;
    int sel;
    bit ab;
    clr = 3'b000;
    m_done = 3'b000;
    if (!m_busy) begin
      eff = m_pend & ~c;
      sel = -1;
      for (int i = 0; i < 3; i++) if (eff[i]) sel = i;
      if (sel >= 0) begin
        m_busy = 1; m_ch = sel; m_on = 1; m_left = ON_C[sel] * D; m_beeps = 0;
        clr[sel] = 1'b1;
      end
    end else begin
      ab = c[m_ch];
`ifdef BUZZER_SCHED_PREEMPT_EN
      for (int i = m_ch + 1; i < 3; i++) if (m_pend[i]) ab = 1;
`endif
      if (ab) begin
        m_busy = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_on) begin
            m_beeps++;
            if (CNT_C[m_ch] != 0 && m_beeps == CNT_C[m_ch]) begin
              m_busy = 0; m_done[m_ch] = 1'b1;
            end else if (OFF_C[m_ch] == 0) begin
              m_left = ON_C[m_ch] * D;
            end else begin
              m_on = 0; m_left = OFF_C[m_ch] * D;
            end
          end else begin
            m_on = 1; m_left = ON_C[m_ch] * D;
          end
        end
      end
    end
    m_pend = ((m_pend & ~clr) | r) & ~c;
  endtask

  // One clock: drive inputs, step the model at the edge, return at negedge.
  task automatic cycle(input logic [2:0] r, input logic [2:0] c);
    req = r; cancel = c;
    @(posedge clk1);
    model_step(r, c);
    @(negedge clk1);
    req = 3'b000; cancel = 3'b000;
  endtask

  // Waveform statistics gathered by the directed scenarios.
  int hi_q[$], lo_q[$], hi_end_t[$], done_q[$], done_t[$], ch_q[$], gap_q[$];
  int cur_hi, cur_lo, cur_idle, tnow;
  bit prev_busy, seen_busy;

  task automatic clear_stats();
    hi_q.delete(); lo_q.delete(); hi_end_t.delete(); done_q.delete();
    done_t.delete(); ch_q.delete(); gap_q.delete();
    cur_hi = 0; cur_lo = 0; cur_idle = 0; prev_busy = busy; seen_busy = 0;
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] c);
    cycle(r, c);
    tnow++;
    if (buzz_en) cur_hi++;
    else if (cur_hi > 0) begin hi_q.push_back(cur_hi); hi_end_t.push_back(tnow); cur_hi = 0; end
    if (busy && !buzz_en) cur_lo++;
    else if (cur_lo > 0) begin lo_q.push_back(cur_lo); cur_lo = 0; end
    if (busy && !prev_busy) begin
      ch_q.push_back(int'(active_ch));
      if (seen_busy) gap_q.push_back(cur_idle);
    end
    if (busy) begin cur_idle = 0; seen_busy = 1; end else cur_idle++;
    for (int i = 0; i < 3; i++) if (done[i]) begin done_q.push_back(i); done_t.push_back(tnow); end
    prev_busy = busy;
  endtask

  task automatic measure(input int n);
    for (int k = 0; k < n; k++) step(3'b000, 3'b000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk1); @(negedge clk1);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (buzz_en !== 1'b0) begin errors++; $display("FAIL reset_buzz: got %b expected 0", buzz_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", active_ch); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", done); end
    @(negedge clk1); @(negedge clk1);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    clear_stats();
    step(3'b001, 3'b000);
    measure(600);
    checks++; if (hi_q.size() !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", hi_q.size()); end
    else begin checks++; if (hi_q[0] !== 500) begin errors++; $display("FAIL single_len: got %0d expected 500", hi_q[0]); end end
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", done_q.size()); end
    else begin
      checks++; if (done_q[0] !== 0) begin errors++; $display("FAIL single_done_ch: got %0d expected 0", done_q[0]); end
      if (hi_end_t.size() == 1) begin
        checks++; if (done_t[0] !== hi_end_t[0]) begin errors++; $display("FAIL single_done_time: got %0d expected %0d", done_t[0], hi_end_t[0]); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL single_ch_end: got %0d expected 0", active_ch); end
  endtask

  task automatic test_triple();
    clear_stats();
    step(3'b010, 3'b000);
    measure(5100);
    checks++; if (hi_q.size() !== 3) begin errors++; $display("FAIL triple_pulses: got %0d expected 3", hi_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (hi_q[i] !== 1000) begin errors++; $display("FAIL triple_on%0d: got %0d expected 1000", i, hi_q[i]); end
    end
    checks++; if (lo_q.size() !== 2) begin errors++; $display("FAIL triple_gaps: got %0d expected 2", lo_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if (lo_q[i] !== 1000) begin errors++; $display("FAIL triple_off%0d: got %0d expected 1000", i, lo_q[i]); end
    end
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL triple_done_cnt: got %0d expected 1", done_q.size()); end
    else begin
      checks++; if (done_q[0] !== 1) begin errors++; $display("FAIL triple_done_ch: got %0d expected 1", done_q[0]); end
      if (hi_end_t.size() == 3) begin
        checks++; if (done_t[0] !== hi_end_t[2]) begin errors++; $display("FAIL triple_done_time: got %0d expected %0d", done_t[0], hi_end_t[2]); end
      end
    end
  endtask

  task automatic test_alarm_cancel();
    clear_stats();
    step(3'b100, 3'b000);
    measure(6200);
    checks++; if (buzz_en !== 1'b1) begin errors++; $display("FAIL alarm_on: got %b expected 1", buzz_en); end
    checks++; if (hi_q.size() !== 1 || lo_q.size() !== 1) begin errors++; $display("FAIL alarm_shape: got %0d/%0d expected 1/1", hi_q.size(), lo_q.size()); end
    else begin
      checks++; if (hi_q[0] !== 2500) begin errors++; $display("FAIL alarm_on_len: got %0d expected 2500", hi_q[0]); end
      checks++; if (lo_q[0] !== 2500) begin errors++; $display("FAIL alarm_off_len: got %0d expected 2500", lo_q[0]); end
    end
    step(3'b000, 3'b100);
    checks++; if (buzz_en !== 1'b0) begin errors++; $display("FAIL cancel_buzz: got %b expected 0", buzz_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    measure(10);
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL cancel_done: got %0d pulses expected 0", done_q.size()); end
  endtask

  task automatic test_priority();
    clear_stats();
    step(3'b011, 3'b000);
    measure(5600);
    checks++; if (ch_q.size() !== 2) begin errors++; $display("FAIL prio_patterns: got %0d expected 2", ch_q.size()); end
    else begin
      checks++; if (ch_q[0] !== 1 || ch_q[1] !== 0) begin errors++; $display("FAIL prio_order: got %0d,%0d expected 1,0", ch_q[0], ch_q[1]); end
    end
    checks++; if (gap_q.size() !== 1) begin errors++; $display("FAIL prio_gaps: got %0d expected 1", gap_q.size()); end
    else begin checks++; if (gap_q[0] !== 1) begin errors++; $display("FAIL prio_idle_len: got %0d expected 1", gap_q[0]); end end
    checks++; if (done_q.size() !== 2) begin errors++; $display("FAIL prio_done_cnt: got %0d expected 2", done_q.size()); end
    else begin
      checks++; if (done_q[0] !== 1 || done_q[1] !== 0) begin errors++; $display("FAIL prio_done_order: got %0d,%0d expected 1,0", done_q[0], done_q[1]); end
    end
    checks++; if (hi_q.size() !== 4) begin errors++; $display("FAIL prio_pulses: got %0d expected 4", hi_q.size()); end
    else begin checks++; if (hi_q[3] !== 500) begin errors++; $display("FAIL prio_ch0_len: got %0d expected 500", hi_q[3]); end end
  endtask

  task automatic test_simultaneous();
    clear_stats();
    step(3'b001, 3'b001);
    measure(50);
    checks++; if (ch_q.size() !== 0) begin errors++; $display("FAIL reqcancel_play: got %0d patterns expected 0", ch_q.size()); end
    clear_stats();
    step(3'b010, 3'b000);
    measure(1500);
    step(3'b010, 3'b000);
    measure(10000);
    checks++; if (done_q.size() !== 2) begin errors++; $display("FAIL rereq_done: got %0d expected 2", done_q.size()); end
    checks++; if (hi_q.size() !== 6) begin errors++; $display("FAIL rereq_pulses: got %0d expected 6", hi_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rereq_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_preempt();
    clear_stats();
    step(3'b010, 3'b000);
    measure(300);
    step(3'b100, 3'b000);
`ifdef BUZZER_SCHED_PREEMPT_EN
    step(3'b000, 3'b000);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL preempt_idle: got %b expected 0", busy); end
    step(3'b000, 3'b000);
    checks++; if (active_ch !== 2'd2) begin errors++; $display("FAIL preempt_ch: got %0d expected 2", active_ch); end
    measure(100);
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL preempt_done: got %0d expected 0", done_q.size()); end
`else
    measure(5000);
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL nopreempt_done: got %0d expected 1", done_q.size()); end
    else begin checks++; if (done_q[0] !== 1) begin errors++; $display("FAIL nopreempt_done_ch: got %0d expected 1", done_q[0]); end end
`endif
    checks++; if (ch_q.size() !== 2) begin errors++; $display("FAIL preempt_patterns: got %0d expected 2", ch_q.size()); end
    else begin
      checks++; if (ch_q[0] !== 1 || ch_q[1] !== 2) begin errors++; $display("FAIL preempt_order: got %0d,%0d expected 1,2", ch_q[0], ch_q[1]); end
    end
    step(3'b000, 3'b100);
    measure(5);
  endtask

  task automatic test_reset_mid();
    step(3'b100, 3'b000);
    measure(100);
    step(3'b001, 3'b000);
    rst_n = 1'b0;
    #1;
    checks++; if (buzz_en !== 1'b0) begin errors++; $display("FAIL midreset_buzz: got %b expected 0", buzz_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    @(negedge clk1); @(negedge clk1);
    rst_n = 1'b1;
    model_reset();
    clear_stats();
    measure(50);
    checks++; if (ch_q.size() !== 0) begin errors++; $display("FAIL midreset_pending: got %0d patterns expected 0", ch_q.size()); end
  endtask

  task automatic test_random();
    logic [2:0] r, c;
    do_reset();
    for (int n = 0; n < 20000; n++) begin
      r = 3'b000; c = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 599) == 0) r[i] = 1'b1;
        if ($urandom_range(0, 1999) == 0) c[i] = 1'b1;
      end
      cycle(r, c);
      checks++; if (buzz_en !== (m_busy && m_on)) begin errors++; $display("FAIL rand_buzz @%0d: got %b expected %b", n, buzz_en, (m_busy && m_on)); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy @%0d: got %b expected %b", n, busy, m_busy); end
      checks++; if (active_ch !== (m_busy ? 2'(m_ch) : 2'd0)) begin errors++; $display("FAIL rand_ch @%0d: got %0d expected %0d", n, active_ch, (m_busy ? m_ch : 0)); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done @%0d: got %b expected %b", n, done, m_done); end
    end
  endtask

  initial begin
    tnow = 0;
    model_reset();
    test_reset();
    test_single();
    test_triple();
    test_alarm_cancel();
    test_priority();
    test_simultaneous();
    test_preempt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/buzzer_sched.md
Name: buzzer_sched

Overview:
Schedules and shares the single board buzzer between three requesters: key click (ch0), timer expiry (ch1) and alarm (ch2). Each channel has a fixed beep pattern: on-time, off-time and beep count, with count 0 meaning repeat until cancelled. The block arbitrates by strict priority, with ch2 highest. It sequences the pattern on a millisecond time base and drives buzz_en into the enable of the PWM tone generator.

Parameters:
CLK_HZ, 50000000, clk1 frequency in Hz
TICK_HZ, 1000, time-base tick rate; TICK_DIV = CLK_HZ/TICK_HZ clk1 cycles per tick
ON0_MS, 50, ch0 on-time in ticks (must be >=1)
OFF0_MS, 0, ch0 off-time in ticks
CNT0, 1, ch0 beep count (0 = continuous)
ON1_MS, 100, ch1 on-time
OFF1_MS, 100, ch1 off-time
CNT1, 3, ch1 beep count
ON2_MS, 250, ch2 on-time
OFF2_MS, 250, ch2 off-time
CNT2, 0, ch2 beep count

Ports:
clk1  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req  input  3  one-cycle request pulse per channel, bit i = ch i
cancel  input  3  one-cycle cancel pulse per channel
buzz_en  output  1  high while a beep is sounding; feeds the tone generator enable
busy  output  1  high in any state other than IDLE
active_ch  output  2  channel being played; valid while busy; 0 when idle
done  output  3  one-cycle pulse on bit i when ch i completes its full pattern

Behaviour:
- Reset: buzz_en=0, busy=0, active_ch=0, done=0, pending=0, state=IDLE, all counters 0.
- pending[i] is set by req[i] and cleared by cancel[i]. When req[i] and cancel[i] arrive in the same cycle, cancel wins. req on the active channel sets pending again, so the pattern replays after the current one ends.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick on the terminal count. It is held at 0 in IDLE, so on/off durations are exact multiples of TICK_DIV cycles.
- FSM states: IDLE, ON, OFF.
- IDLE: if any pending bit is set, the next cycle selects the highest set index. On that transition: active_ch<=ch, pending[ch]<=0, ms_cnt<=0, beep_cnt<=0, state<=ON.
- ON: buzz_en=1. On each tick, if ms_cnt==ON_MS-1, then ms_cnt<=0 and beep_cnt+1. Otherwise ms_cnt increments.
- At the end of ON: if CNT!=0 and beep_cnt+1==CNT, go to IDLE with done[ch] pulsed for one cycle. Else if OFF_MS==0, go straight back to ON (buzz_en stays high). Otherwise go to OFF.
- OFF: buzz_en=0. When a tick arrives with ms_cnt==OFF_MS-1, go to ON.
- buzz_en is registered and rises on the cycle the state becomes ON. ON lasts exactly ON_MS*TICK_DIV cycles.
- cancel[active_ch] while busy: the next state is IDLE, buzz_en goes low the following cycle, and done is not pulsed.
- Requests from other channels arriving while busy stay pending and are served in priority order after return to IDLE. One IDLE cycle always separates consecutive patterns.
- Counter widths: ms_cnt 16 bits; beep_cnt 8 bits, wrapping when CNT=0.
- Reset mid-pattern: immediate return to reset values; pending requests are lost.

Optional Feature:
Macro BUZZER_SCHED_PREEMPT_EN.
- Defined: while busy, a pending channel with index above active_ch aborts the current pattern. The aborted channel gets no done pulse and is not re-queued. The FSM passes through IDLE for one cycle, then starts the higher channel.
- Undefined: no preemption; the current pattern always runs to completion or cancel.

Test Plan:
- Bench settings CLK_HZ=10000, TICK_HZ=1000 (TICK_DIV=10). Single-beep: req=3'b001 -> buzz_en high for exactly 500 cycles, then done[0] pulse, busy drops, active_ch=0.
- Triple beep: req[1] -> buzz_en shows three 1000-cycle high pulses separated by 1000-cycle lows, then one done[1] pulse after the third pulse.
- Continuous alarm: req[2] -> 2500/2500-cycle toggling with no done. cancel[2] mid-ON -> buzz_en low within 2 cycles, busy=0, no done[2].
- Priority: req=3'b011 in the same cycle -> ch1 plays first (active_ch=1), then ch0 after one IDLE cycle. Both done bits pulse, in order 1 then 0.
- Simultaneous events: req[0] and cancel[0] in the same cycle -> nothing plays. Re-req of ch1 during its own playback -> the pattern plays twice.
- With BUZZER_SCHED_PREEMPT_EN: req[2] during a ch1 ON -> ch1 aborts without done[1], and active_ch becomes 2 two cycles later. Without the macro: ch1 completes first.
